sum_collect_fifo: RTL and testbench
===================================

# sum_collect_fifo

Result-collection stage placed directly downstream of the registered adder. It captures each single-cycle `valid`/`y` result pulse into a small FIFO and re-presents the results on a ready/valid interface for a slower consumer. The adder has no backpressure, so this block also counts and flags results lost to overflow.

## Interface
- `W`, 8: data width; must match the adder's `W`.
- `DEPTH`, 4: number of FIFO entries; power of two, at least 2.
- `clk` input 1: sole clock; rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: result strobe; connects to the adder's `valid`.
- `in_data` input W: result value; connects to the adder's `y`. Sampled only when `in_valid` is 1.
- `out_valid` output 1: head entry is available.
- `out_data` output W: head entry value. Don't-care when `out_valid` is 0.
- `out_ready` input 1: consumer accepts the head entry.
- `count` output $clog2(DEPTH)+1: number of occupied entries, 0..DEPTH.
- `overflow` output 1: sticky flag; set when any result has been dropped.
- `drop_cnt` output 8: number of dropped results; saturates at 255.

## Operation
- Storage: `DEPTH` x `W` register array, a write pointer and a read pointer. Each pointer is $clog2(DEPTH) bits and wraps modulo `DEPTH`.
- Push: `in_valid` is 1 and the FIFO has space. Space exists when `count` < `DEPTH`, or when `count` == `DEPTH` and a pop happens in the same cycle.
- Pop: `out_valid` and `out_ready` are both 1.
- Simultaneous push and pop: both are performed and `count` is unchanged. This holds when full, so no drop occurs.
- Empty FIFO: no bypass. A push into an empty FIFO is not poppable in the same cycle.
- Drop: `in_valid` is 1, `count` == `DEPTH` and no pop this cycle.
  - `in_data` is discarded.
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at 255.
- `overflow` clears only on reset.
- `out_valid` equals (`count` != 0). `out_data` is the array entry at the read pointer, read combinationally from registered state.
- `out_ready` while empty has no effect.
- Reset values while `rst` is 1: `count` 0, both pointers 0, `out_valid` 0, `overflow` 0, `drop_cnt` 0. Array contents are not reset.
- Reset asserted mid-operation: all buffered entries are discarded immediately and asynchronously. The first push after `rst` deasserts lands in entry 0.
- Arithmetic: `count` changes by +1, −1 or 0 per cycle and never exceeds `DEPTH`. `drop_cnt` never wraps.

## Timing
- Push latency: `in_valid` sampled at edge N gives `out_valid` = 1 and `out_data` = that value after edge N, provided the FIFO was empty.
- Pop at edge N: the next entry, or `out_valid` = 0, is visible after edge N.
- `count`, `overflow` and `drop_cnt` all update on the same edge as the event that causes them.
- Back-to-back `in_valid` on every cycle is accepted until the FIFO is full.
- No combinational path from `out_ready` to `out_valid` or `out_data`.
- No combinational path from any input to any output.

## Structure
- Package `sum_collect_pkg` holds:
  - `DEPTH_DEFAULT` = 4
  - `DROP_CNT_W` = 8
  - `DROP_CNT_MAX` = 255
  - a `ptr_t` typedef helper, or a `$clog2`-based width localparam pattern
- Single flat module: pointer/count logic and a small register array. No sub-module is natural at this size.

## Test plan
- Reset, then 3 pushes (0x10, 0x20, 0x30) with `out_ready` held at 0 -> `count` = 3, `out_data` = 0x10. Then `out_ready` = 1 for 3 cycles -> 0x10, 0x20, 0x30 in order, then `out_valid` = 0.
- Push 5 values into `DEPTH` = 4 with `out_ready` = 0 -> the first 4 are kept, `overflow` = 1, `drop_cnt` = 1, `count` = 4. The fifth value never appears at the output.
- Full FIFO with `in_valid` and `out_ready` both 1 in the same cycle -> `count` stays 4, `drop_cnt` unchanged, and the new value appears 4 pops later.
- 300 pushes while full and `out_ready` = 0 -> `drop_cnt` = 255 and stays at 255.
- Wrap-around: 10 push/pop pairs with values 1..10, pushing and popping every cycle -> output is 1..10 in order and `count` never exceeds 1.
- Assert `rst` mid-stream with `count` = 3 and `overflow` = 1 -> immediately `out_valid` = 0, `count` = 0, `overflow` = 0, `drop_cnt` = 0. After release, push 0x55 -> `out_data` = 0x55 the next cycle.

Source files
------------

// File: rtl/sum_collect_pkg.sv
// Shared constants for the adder result-collection FIFO.
package sum_collect_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int DROP_CNT_W    = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

endpackage

// File: rtl/sum_collect_fifo.sv
// Captures single-cycle adder result pulses into a small FIFO and re-presents them
// on a ready/valid port; results arriving while full with no pop are dropped and counted.
module sum_collect_fifo
  import sum_collect_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [W-1:0]            mem_q [DEPTH];
  ptr_t                    wr_ptr_q, wr_ptr_d;
  ptr_t                    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic not_empty, full, pop, push, drop;

  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = not_empty && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != DROP_CNT_MAX) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: the data array is deliberately not reset; count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = not_empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sum_collect_fifo.sv
// Directed self-checking bench for sum_collect_fifo (W=8, DEPTH=4).
module tb_sum_collect_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  sum_collect_fifo #(.W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then settled and inputs can change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [7:0] vals [], input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] v [];
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    step();
    rst = 1'b0;
    step();

    // Basic ordering, single-cycle push latency
    in_valid = 1'b1; in_data = 8'h10;
    step();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'h10);
    v = '{8'h20, 8'h30};
    push_n(v, 2);
    check("t1_count", count, 3);
    check("t1_head", out_data, 8'h10);
    pop_expect("t1_p0", 8'h10);
    pop_expect("t1_p1", 8'h20);
    pop_expect("t1_p2", 8'h30);
    check("t1_empty", out_valid, 0);
    check("t1_count0", count, 0);

    // Overflow: fifth value dropped
    v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_n(v, 5);
    check("t2_count", count, 4);
    check("t2_ovf", overflow, 1);
    check("t2_drop", drop_cnt, 1);
    pop_expect("t2_p0", 8'h01);
    pop_expect("t2_p1", 8'h02);
    pop_expect("t2_p2", 8'h03);
    pop_expect("t2_p3", 8'h04);
    check("t2_empty", out_valid, 0);

    // Simultaneous push and pop while full
    v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    push_n(v, 4);
    in_valid = 1'b1; in_data = 8'hB5; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t3_count", count, 4);
    check("t3_drop", drop_cnt, 1);
    pop_expect("t3_p0", 8'hA2);
    pop_expect("t3_p1", 8'hA3);
    pop_expect("t3_p2", 8'hA4);
    pop_expect("t3_p3", 8'hB5);
    check("t3_empty", out_valid, 0);

    // Drop counter saturation
    v = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    push_n(v, 4);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      step();
      if (i == 252) check("t4_drop254", drop_cnt, 254);
    end
    check("t4_drop_sat", drop_cnt, 255);
    in_data = 8'hEE;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    check("t4_drop_hold", drop_cnt, 255);
    check("t4_count", count, 4);
    pop_expect("t4_p0", 8'hC0);
    pop_expect("t4_p1", 8'hC1);
    pop_expect("t4_p2", 8'hC2);
    pop_expect("t4_p3", 8'hC3);
    check("t4_empty", out_valid, 0);

    // Wrap-around streaming; out_ready while empty must be harmless
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      check($sformatf("t5_data%0d", i), out_data, i);
      check($sformatf("t5_count%0d", i), count, 1);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("t5_empty", out_valid, 0);
    check("t5_drop", drop_cnt, 255);

    // Asynchronous reset mid-stream
    v = '{8'h61, 8'h62, 8'h63};
    push_n(v, 3);
    check("t6_count3", count, 3);
    check("t6_ovf1", overflow, 1);
    rst = 1'b1;
    #2;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_ovf", overflow, 0);
    check("t6_rst_drop", drop_cnt, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    check("t6_valid", out_valid, 1);
    check("t6_data", out_data, 8'h55);
    check("t6_count1", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
